resadd_requant_stage: RTL and testbench
=======================================

Name: resadd_requant_stage

Overview:
- Pipelined stage directly upstream of the LayerNorm in the self-output layer.
- Consumes the int32 accumulator stream from the attention-output × W_self_output matmul and the int8 residual stream.
- Per element: adds the per-column bias, requantizes to int8 with (M, E), adds the residual, and emits the widened sum to LayerNorm.
- Tracks token/column position, marks row ends, and signals completion of a TOKENS×EMBED tensor.

Parameters:
TOKENS, 32, rows (tokens) per tensor
EMBED, 768, columns per row
LANES, 16, elements per stream beat; EMBED % LANES == 0
COLS, EMBED/LANES (derived, 48), beats per row
OUT_W, 16, per-lane output width (signed)

Ports:
clk  in  1  stage clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a tensor
busy  out  1  high from start until final output beat handshake
done  out  1  one-cycle pulse on final output beat handshake
requant_m  in  32  unsigned multiplier M, latched on start
requant_e  in  8  right shift E (0..63), latched on start
bias_wr_en  in  1  bias table write strobe
bias_wr_addr  in  $clog2(COLS)  beat-column index
bias_wr_data  in  LANES*32  LANES signed int32 biases
acc_data  in  LANES*32  signed int32 matmul accumulators, lane 0 in LSBs
acc_valid  in  1  accumulator beat valid
acc_ready  out  1  accumulator beat accepted
res_data  in  LANES*8  signed int8 residuals
res_valid  in  1  residual beat valid
res_ready  out  1  residual beat accepted
out_data  out  LANES*OUT_W  signed sums to LayerNorm
out_valid  out  1  output beat valid
out_last  out  1  high on last beat of each row (column COLS-1)
out_ready  in  1  LayerNorm accepts beat

Behaviour:
- Reset values: busy=0, done=0, acc_ready=0, res_ready=0, out_valid=0, out_last=0, out_data=0. Counters zeroed, pipeline valids cleared. Bias table contents are not reset.
- Bias table: COLS×(LANES×32) registers with asynchronous read.
  - Write on bias_wr_en only while busy=0.
  - Writes while busy=1 are ignored.
- Start:
  - start while busy=0 latches M/E, clears in_col/in_row/out_col/out_row, and sets busy=1 on the next cycle.
  - start while busy=1 is ignored.
- Join: adv = !out_valid || out_ready (global pipeline enable). fire = busy && in_pending && acc_valid && res_valid && adv, where in_pending is high until TOKENS*COLS beats have been accepted.
  - acc_ready = busy && in_pending && res_valid && adv.
  - res_ready = busy && in_pending && acc_valid && adv.
  - Both streams are always consumed together, never individually.
- Pipeline: 3 register stages, all advancing on adv. Latency is 3 cycles from fire to out_valid with out_ready held high; throughput is one beat per cycle.
  - S1: t = sext33(acc) + sext33(bias[in_col]); residual delayed.
  - S2: p = t × M as a signed 66-bit product.
  - S3: r = (p + (E>0 ? 1<<(E-1) : 0)) >>> E (round half up, arithmetic shift). q = saturate r to [-128,127]. out = sext_OUT_W(q + residual), range [-256,254].
- Counters:
  - in_col increments on fire and wraps at COLS-1 → 0, incrementing in_row.
  - out_col/out_row advance on out_valid && out_ready.
  - out_last = (out_col == COLS-1) while out_valid.
- Completion: on the handshake of beat (out_row TOKENS-1, out_col COLS-1), done pulses for 1 cycle and busy drops the next cycle. Further input is not accepted until the next start.
- Backpressure: while out_valid && !out_ready, all stages hold, no data is lost or reordered, and out_data stays stable.
- Reset mid-operation: pipeline contents are discarded immediately; no done pulse is produced.

Optional Feature:
- Macro: RESADD_SAT_STATS_EN.
- Defined:
  - Adds output port sat_count (out, 32): the number of lanes whose r fell outside [-128,127] during the current tensor.
  - Cleared on start and on reset; saturates at 0xFFFFFFFF.
  - Counts only beats that advance out of S3.
- Undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
- Identity requant: M=256, E=8, bias=5, acc=100, res=-3 on all lanes → out=102; out_last on beat 47 of each row; done once after 1536 output beats; busy low the cycle after.
- Saturation: M=256, E=8, acc=1000, bias=0, res=127 → out=254; acc=-1000, res=-128 → out=-256. With RESADD_SAT_STATS_EN: sat_count=32 after one beat of each.
- Rounding: M=128, E=8, bias=0, acc=-3 → -384+128=-256>>>8 → q=-1. acc=3 → q=2 (1.5 rounds up). E=0, M=1, acc=5 → q=5.
- Backpressure/skew: random stalls on out_ready (including 5 consecutive low cycles mid-row), res_valid lagging acc_valid by 0–3 cycles → output sequence matches the golden model exactly; acc/res never accepted separately.
- Control corners: start asserted while busy is ignored; bias_wr_en while busy leaves the table unchanged (verify via next tensor); a second tensor back-to-back after done uses the newly latched M/E.
- Reset mid-tensor: assert rst_n=0 at beat 700 → all outputs are at reset values the same cycle; a fresh start then yields a complete, correct tensor with a single done.

Source files
------------

// File: rtl/resadd_requant_stage.sv
// Residual-add / requantize stage feeding LayerNorm: bias add, int8 requant by (M, E), residual add.
// Optional RESADD_SAT_STATS_EN adds a per-tensor saturated-lane counter (sat_count).
`timescale 1ns/1ps
module resadd_requant_stage #(
    parameter int TOKENS = 32,
    parameter int EMBED  = 768,
    parameter int LANES  = 16,
    parameter int OUT_W  = 16,
    localparam int COLS  = EMBED / LANES,
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    input  logic [31:0]             requant_m,
    input  logic [7:0]              requant_e,
    input  logic                    bias_wr_en,
    input  logic [CW-1:0]           bias_wr_addr,
    input  logic [LANES*32-1:0]     bias_wr_data,
    input  logic [LANES*32-1:0]     acc_data,
    input  logic                    acc_valid,
    output logic                    acc_ready,
    input  logic [LANES*8-1:0]      res_data,
    input  logic                    res_valid,
    output logic                    res_ready,
`ifdef RESADD_SAT_STATS_EN
    output logic [31:0]             sat_count,
`endif
    output logic [LANES*OUT_W-1:0]  out_data,
    output logic                    out_valid,
    output logic                    out_last,
    input  logic                    out_ready
);
    localparam int RW = (TOKENS > 1) ? $clog2(TOKENS) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(TOKENS - 1);

    logic                   busy_q, in_pending_q;
    logic [31:0]            m_q;
    logic [7:0]             e_q;
    logic [CW-1:0]          in_col_q, out_col_q;
    logic [RW-1:0]          in_row_q, out_row_q;
    logic                   v1_q, v2_q, v3_q;
    logic [LANES*33-1:0]    t_d, t_q;
    logic [LANES*66-1:0]    p_d, p_q;
    logic [LANES*8-1:0]     res1_q, res2_q;
    logic [LANES*OUT_W-1:0] out_d, out_q;
    logic [LANES-1:0]       sat_d;
    logic [LANES*32-1:0]    bias_mem [COLS];
    logic [LANES*32-1:0]    bias_rd;
    logic signed [32:0]     m_s;
    logic signed [65:0]     rnd;
    logic adv, fire, out_fire, tensor_end, start_ok;

    assign adv        = !v3_q || out_ready;
    assign fire       = busy_q && in_pending_q && acc_valid && res_valid && adv;
    assign out_fire   = v3_q && out_ready;
    assign tensor_end = out_fire && (out_col_q == COL_LAST) && (out_row_q == ROW_LAST);
    assign start_ok   = start && !busy_q;

    assign acc_ready = busy_q && in_pending_q && res_valid && adv;
    assign res_ready = busy_q && in_pending_q && acc_valid && adv;
    assign busy      = busy_q;
    assign done      = tensor_end;
    assign out_valid = v3_q;
    assign out_last  = v3_q && (out_col_q == COL_LAST);
    assign out_data  = out_q;

    // Bias table is deliberately left out of reset; it is reloaded between tensors.
    always_ff @(posedge clk) begin
        if (bias_wr_en && !busy_q && (int'(bias_wr_addr) < COLS)) begin
            bias_mem[bias_wr_addr] <= bias_wr_data;
        end
    end
    assign bias_rd = bias_mem[in_col_q];

    assign m_s = $signed({1'b0, m_q});
    assign rnd = (e_q == 8'd0) ? 66'sd0 : (66'sd1 <<< (e_q - 8'd1));

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic signed [31:0] acc_l, bias_l;
        logic signed [32:0] t_l;
        logic signed [65:0] prod_l, p_l, r_l;
        logic signed [7:0]  q_l, res_l;
        logic        [8:0]  sum_l;

        assign acc_l  = acc_data[gi*32 +: 32];
        assign bias_l = bias_rd[gi*32 +: 32];
        assign t_d[gi*33 +: 33] = {acc_l[31], acc_l} + {bias_l[31], bias_l};

        assign t_l    = t_q[gi*33 +: 33];
        assign prod_l = t_l * m_s;
        assign p_d[gi*66 +: 66] = prod_l;

        // Round half up, then floor via arithmetic shift.
        assign p_l   = p_q[gi*66 +: 66];
        assign r_l   = (p_l + rnd) >>> e_q;
        assign sat_d[gi] = (r_l > 66'sd127) || (r_l < -66'sd128);
        assign q_l   = (r_l > 66'sd127) ? 8'sd127 : (r_l < -66'sd128) ? -8'sd128 : r_l[7:0];
        assign res_l = res2_q[gi*8 +: 8];
        assign sum_l = {q_l[7], q_l} + {res_l[7], res_l};
        assign out_d[gi*OUT_W +: OUT_W] = {{(OUT_W-9){sum_l[8]}}, sum_l};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;  in_pending_q <= 1'b0;
            m_q <= '0;       e_q <= '0;
            in_col_q <= '0;  in_row_q <= '0;
            out_col_q <= '0; out_row_q <= '0;
            v1_q <= 1'b0;    v2_q <= 1'b0;  v3_q <= 1'b0;
            t_q <= '0;       p_q <= '0;     out_q <= '0;
            res1_q <= '0;    res2_q <= '0;
        end else begin
            if (start_ok) begin
                busy_q <= 1'b1;  in_pending_q <= 1'b1;
                m_q <= requant_m; e_q <= requant_e;
                in_col_q <= '0;  in_row_q <= '0;
                out_col_q <= '0; out_row_q <= '0;
            end else begin
                if (fire) begin
                    if (in_col_q == COL_LAST) begin
                        in_col_q <= '0;
                        in_row_q <= in_row_q + 1'b1;
                        if (in_row_q == ROW_LAST) in_pending_q <= 1'b0;
                    end else begin
                        in_col_q <= in_col_q + 1'b1;
                    end
                end
                if (out_fire) begin
                    if (out_col_q == COL_LAST) begin
                        out_col_q <= '0;
                        out_row_q <= out_row_q + 1'b1;
                    end else begin
                        out_col_q <= out_col_q + 1'b1;
                    end
                end
                if (tensor_end) busy_q <= 1'b0;
            end
            if (adv) begin
                v1_q <= fire;  t_q <= t_d;  res1_q <= res_data;
                v2_q <= v1_q;  p_q <= p_d;  res2_q <= res1_q;
                v3_q <= v2_q;  out_q <= out_d;
            end
        end
    end

`ifdef RESADD_SAT_STATS_EN
    localparam int SNW = $clog2(LANES + 1);
    logic [SNW-1:0] sat_n_d, sat_n_q;
    logic [31:0]    sat_q;
    logic [32:0]    sat_sum;

    always_comb begin
        sat_n_d = '0;
        for (int i = 0; i < LANES; i++) sat_n_d = sat_n_d + SNW'(sat_d[i]);
    end
    assign sat_sum   = {1'b0, sat_q} + 33'(sat_n_q);
    assign sat_count = sat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_n_q <= '0;
            sat_q   <= '0;
        end else begin
            if (adv) sat_n_q <= sat_n_d;
            if (start_ok) sat_q <= '0;
            else if (out_fire) sat_q <= sat_sum[32] ? 32'hFFFF_FFFF : sat_sum[31:0];
        end
    end
`endif
endmodule

// File: tb/tb_resadd_requant_stage.sv
// Self-checking bench for resadd_requant_stage: table vectors, full tensors vs. a wide-arithmetic model,
// output stalls, residual skew, control corners and mid-tensor reset.
`timescale 1ns/1ps
module tb_resadd_requant_stage;
    localparam int TOKENS = 32;
    localparam int EMBED  = 768;
    localparam int LANES  = 16;
    localparam int OUT_W  = 16;
    localparam int COLS   = EMBED / LANES;
    localparam int CW     = $clog2(COLS);
    localparam int NBEATS = TOKENS * COLS;

    logic clk = 1'b0;
    logic rst_n, start, busy, done;
    logic [31:0] requant_m;
    logic [7:0]  requant_e;
    logic bias_wr_en;
    logic [CW-1:0] bias_wr_addr;
    logic [LANES*32-1:0] bias_wr_data, acc_data;
    logic acc_valid, acc_ready, res_valid, res_ready;
    logic [LANES*8-1:0] res_data;
    logic [LANES*OUT_W-1:0] out_data;
    logic out_valid, out_last, out_ready;
`ifdef RESADD_SAT_STATS_EN
    logic [31:0] sat_count;
`endif

    resadd_requant_stage #(.TOKENS(TOKENS), .EMBED(EMBED), .LANES(LANES), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .requant_m(requant_m), .requant_e(requant_e),
        .bias_wr_en(bias_wr_en), .bias_wr_addr(bias_wr_addr), .bias_wr_data(bias_wr_data),
        .acc_data(acc_data), .acc_valid(acc_valid), .acc_ready(acc_ready),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
`ifdef RESADD_SAT_STATS_EN
        .sat_count(sat_count),
`endif
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int acc; int bias; int res; int unsigned m; int e; int exp; bit sat;
    } vec_t;
    typedef struct {
        logic [LANES*OUT_W-1:0] data; bit last; bit fin;
    } exp_t;

    int n_checks = 0, n_err = 0;
    int bias_m [COLS][LANES];
    int unsigned m_cur;
    int e_cur;
    exp_t exp_q [$];
    bit mon_en = 1'b0;
    bit rdy_random = 1'b0;
    int total_hs = 0, done_cnt = 0, force_at = -1;

    task automatic chk(input string name, input bit ok, input logic [255:0] act, input logic [255:0] expv);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, expv);
        end
    endtask

    // Reference: exact wide arithmetic straight from the requant rules.
    function automatic logic [15:0] ref_out(int acc, int bias, logic [7:0] res, int unsigned m, int e);
        logic signed [127:0] t, p, r;
        int q;
        t = acc;
        t = t + bias;
        p = t * $signed({96'd0, m});
        if (e > 0) p = p + (128'sd1 <<< (e - 1));
        r = p >>> e;
        if (r > 127) q = 127;
        else if (r < -128) q = -128;
        else q = int'(r);
        q = q + int'($signed(res));
        return 16'(q);
    endfunction

    task automatic write_bias(input int col, input logic [LANES*32-1:0] data);
        bias_wr_en = 1'b1; bias_wr_addr = CW'(col); bias_wr_data = data;
        @(posedge clk); #1;
        bias_wr_en = 1'b0;
    endtask

    task automatic start_tensor(input int unsigned m, input int e);
        m_cur = m; e_cur = e;
        requant_m = m; requant_e = 8'(e); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy == 1'b1, 256'(busy), 256'(1));
    endtask

    task automatic run_tensor(input int mode, input bit poke, input int abort_at);
        logic [LANES*32-1:0] a_v;
        logic [LANES*8-1:0]  r_v;
        exp_t e;
        int col, lag, cyc;
        bit acc_ok;
        for (int b = 0; b < NBEATS; b++) begin
            col = b % COLS;
            for (int l = 0; l < LANES; l++) begin
                if (mode == 0) begin
                    a_v[l*32 +: 32] = 32'd100;
                    r_v[l*8 +: 8]   = 8'hFD;
                end else begin
                    a_v[l*32 +: 32] = 32'(int'($urandom) >>> $urandom_range(0, 31));
                    r_v[l*8 +: 8]   = 8'($urandom);
                end
                e.data[l*OUT_W +: OUT_W] = ref_out(int'(a_v[l*32 +: 32]), bias_m[col][l], r_v[l*8 +: 8], m_cur, e_cur);
            end
            e.last = (col == COLS - 1);
            e.fin  = (b == NBEATS - 1);
            acc_data = a_v; res_data = r_v; acc_valid = 1'b1;
            lag = (mode == 0) ? 0 : $urandom_range(0, 3);
            res_valid = (lag == 0);
            if (poke && b == 100) begin
                start = 1'b1; requant_m = ~m_cur; requant_e = 8'(e_cur ^ 3);
            end
            if (poke && b == 200) begin
                bias_wr_en = 1'b1; bias_wr_addr = '0; bias_wr_data = {LANES{32'h1234_5678}};
            end
            acc_ok = 1'b0; cyc = 0;
            while (!acc_ok) begin
                @(negedge clk);
                acc_ok = acc_valid && acc_ready;
                if (acc_ok) exp_q.push_back(e);
                @(posedge clk); #1;
                start = 1'b0; bias_wr_en = 1'b0;
                cyc++;
                if (cyc >= lag) res_valid = 1'b1;
                if (cyc > 3000) begin
                    chk("input_accept_timeout", 1'b0, 256'(b), 256'(NBEATS));
                    acc_valid = 1'b0; res_valid = 1'b0;
                    return;
                end
            end
            acc_valid = 1'b0; res_valid = 1'b0;
            if (b + 1 == abort_at) return;
        end
    endtask

    task automatic wait_done(input int target);
        for (int k = 0; k < 8000 && done_cnt < target; k++) @(negedge clk);
        chk("done_seen", done_cnt == target, 256'(done_cnt), 256'(target));
        repeat (5) @(negedge clk);
        chk("single_done", done_cnt == target, 256'(done_cnt), 256'(target));
        chk("queue_drained", exp_q.size() == 0, 256'(exp_q.size()), 256'(0));
        chk("busy_idle", busy == 1'b0, 256'(busy), 256'(0));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},      busy == 1'b0,      256'(busy),      256'(0));
        chk({tag, "_done"},      done == 1'b0,      256'(done),      256'(0));
        chk({tag, "_acc_ready"}, acc_ready == 1'b0, 256'(acc_ready), 256'(0));
        chk({tag, "_res_ready"}, res_ready == 1'b0, 256'(res_ready), 256'(0));
        chk({tag, "_out_valid"}, out_valid == 1'b0, 256'(out_valid), 256'(0));
        chk({tag, "_out_last"},  out_last == 1'b0,  256'(out_last),  256'(0));
        chk({tag, "_out_data"},  out_data == '0,    256'(out_data),  256'(0));
    endtask

    // Output readiness: always-on or random, plus one forced 5-cycle stall mid-row.
    initial begin
        int fc, last_forced;
        fc = 0; last_forced = -1;
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rdy_random && total_hs == force_at && last_forced != force_at) begin
                fc = 5; last_forced = force_at;
            end
            if (fc > 0) begin
                out_ready = 1'b0; fc--;
            end else if (rdy_random) out_ready = ($urandom_range(0, 3) != 0);
            else out_ready = 1'b1;
        end
    end

    // Output monitor / scoreboard.
    bit prev_stall = 1'b0, busy_chk = 1'b0;
    logic [LANES*OUT_W-1:0] prev_data;
    always @(negedge clk) begin
        exp_t e;
        bit a_hs, r_hs;
        if (!mon_en) begin
            prev_stall = 1'b0; busy_chk = 1'b0;
        end else begin
            if (busy_chk) begin
                chk("busy_drop", busy == 1'b0, 256'(busy), 256'(0));
                busy_chk = 1'b0;
            end
            a_hs = acc_valid && acc_ready;
            r_hs = res_valid && res_ready;
            if (a_hs || r_hs) chk("joint_accept", a_hs == r_hs, 256'({a_hs, r_hs}), 256'(3));
            if (prev_stall)
                chk("stall_hold", out_valid && out_data == prev_data, 256'(out_data), 256'(prev_data));
            if (out_valid && out_ready) begin
                total_hs++;
                if (exp_q.size() == 0) chk("unexpected_beat", 1'b0, 256'(out_data), 256'(0));
                else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data == e.data, 256'(out_data), 256'(e.data));
                    chk("out_last", out_last == e.last, 256'(out_last), 256'(e.last));
                    chk("done_pulse", done == e.fin, 256'(done), 256'(e.fin));
                    if (e.fin) busy_chk = 1'b1;
                end
            end else if (done) chk("spurious_done", 1'b0, 256'(done), 256'(0));
            if (done) done_cnt++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    vec_t tbl [6];
    initial begin
        logic [LANES*32-1:0] bv;
        logic [LANES*OUT_W-1:0] ev;
        int lat, tgt;
        bit got;

        tbl[0] = '{acc: 100,   bias: 5, res: -3,   m: 256, e: 8, exp: 102,  sat: 1'b0};
        tbl[1] = '{acc: 1000,  bias: 0, res: 127,  m: 256, e: 8, exp: 254,  sat: 1'b1};
        tbl[2] = '{acc: -1000, bias: 0, res: -128, m: 256, e: 8, exp: -256, sat: 1'b1};
        tbl[3] = '{acc: -3,    bias: 0, res: 0,    m: 128, e: 8, exp: -1,   sat: 1'b0};
        tbl[4] = '{acc: 3,     bias: 0, res: 0,    m: 128, e: 8, exp: 2,    sat: 1'b0};
        tbl[5] = '{acc: 5,     bias: 0, res: 0,    m: 1,   e: 0, exp: 5,    sat: 1'b0};

        rst_n = 1'b0; start = 1'b0; requant_m = '0; requant_e = '0;
        bias_wr_en = 1'b0; bias_wr_addr = '0; bias_wr_data = '0;
        acc_data = '0; acc_valid = 1'b0; res_data = '0; res_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-beat vectors, each aborted by reset after its output is seen.
        for (int i = 0; i < 6; i++) begin
            for (int l = 0; l < LANES; l++) begin
                bv[l*32 +: 32] = 32'(tbl[i].bias);
                ev[l*OUT_W +: OUT_W] = 16'(tbl[i].exp);
            end
            write_bias(0, bv);
            start_tensor(tbl[i].m, tbl[i].e);
            for (int l = 0; l < LANES; l++) begin
                acc_data[l*32 +: 32] = 32'(tbl[i].acc);
                res_data[l*8 +: 8]   = 8'(tbl[i].res);
            end
            acc_valid = 1'b1; res_valid = 1'b1;
            got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                @(negedge clk);
                got = acc_ready && res_ready;
                @(posedge clk); #1;
            end
            acc_valid = 1'b0; res_valid = 1'b0;
            chk("vec_accept", got, 256'(got), 256'(1));
            lat = 0;
            for (int k = 0; k < 20 && !out_valid; k++) begin
                @(negedge clk);
                lat++;
            end
            chk("vec_latency", lat == 3, 256'(lat), 256'(3));
            chk($sformatf("vec%0d_data", i), out_data == ev, 256'(out_data), 256'(ev));
            chk("vec_last", out_last == 1'b0, 256'(out_last), 256'(0));
            @(posedge clk); #1;
`ifdef RESADD_SAT_STATS_EN
            chk("vec_sat_count", sat_count == (tbl[i].sat ? 32'(LANES) : 32'd0), 256'(sat_count),
                256'(tbl[i].sat ? LANES : 0));
`endif
            rst_n = 1'b0; #1;
            chk("vec_reset_valid", out_valid == 1'b0 && busy == 1'b0, 256'({out_valid, busy}), 256'(0));
            @(posedge clk); #1;
            rst_n = 1'b1;
        end

        // Tensor A: identity requant, constant data, no stalls.
        for (int c = 0; c < COLS; c++) begin
            for (int l = 0; l < LANES; l++) bias_m[c][l] = 5;
            write_bias(c, {LANES{32'd5}});
        end
        mon_en = 1'b1;
        tgt = done_cnt + 1;
        start_tensor(256, 8);
        run_tensor(0, 1'b0, 0);
        wait_done(tgt);

        // Tensor B: random bias/data, stalls, skew, ignored start and bias write while busy.
        for (int c = 0; c < COLS; c++) begin
            for (int l = 0; l < LANES; l++) begin
                bias_m[c][l] = int'($urandom_range(0, 2000)) - 1000;
                bv[l*32 +: 32] = 32'(bias_m[c][l]);
            end
            write_bias(c, bv);
        end
        rdy_random = 1'b1;
        force_at = total_hs + 30;
        tgt = done_cnt + 1;
        start_tensor($urandom_range(1, 4096), $urandom_range(10, 20));
        run_tensor(1, 1'b1, 0);
        wait_done(tgt);

        // Tensor C: immediately after, new M/E; bias table must be unchanged.
        tgt = done_cnt + 1;
        start_tensor($urandom, $urandom_range(24, 40));
        run_tensor(1, 1'b0, 0);
        wait_done(tgt);

        // Tensor D: reset at beat 700.
        tgt = done_cnt;
        start_tensor($urandom_range(1, 65535), $urandom_range(12, 22));
        run_tensor(1, 1'b0, 700);
        mon_en = 1'b0;
        rst_n = 1'b0; #1;
        chk_reset_outputs("midreset");
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("no_done_after_reset", done_cnt == tgt, 256'(done_cnt), 256'(tgt));
        @(posedge clk); #1;

        // Tensor E: fresh full tensor after reset.
        mon_en = 1'b1;
        tgt = done_cnt + 1;
        start_tensor($urandom_range(1, 65535), $urandom_range(12, 22));
        run_tensor(1, 1'b0, 0);
        wait_done(tgt);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
